// File: rtl/beh_adder_pkg.sv
// Shared types and helpers for the registered adder datapath.
// The status-flag record and the function that derives it live here so the
// flag sub-module and any other consumer decode flags the same way.
package beh_adder_pkg;

    // Verified operand/result width.
    localparam int ADDER_WIDTH = 16;

    // Widest result the flag helper accepts. Narrower results are
    // zero-extended before they reach the helper, so the extra bits do not
    // change the zero or parity flags.
    localparam int ADDER_MAX_WIDTH = 64;

    // ALU-style status flags that travel with every result.
    typedef struct packed {
        logic sign;
        logic zero;
        logic carry;
        logic parity;
        logic overflow;
    } adder_flags_t;

    // Derive the status flags from one addition.
    //   res       : low WIDTH bits of the sum, zero-extended to ADDER_MAX_WIDTH
    //   carry_out : bit WIDTH of the full sum
    //   res_msb   : bit WIDTH-1 of the sum
    //   a_msb     : bit WIDTH-1 of operand A
    //   b_msb     : bit WIDTH-1 of operand B
    // Overflow uses the carry-into-MSB XOR carry-out-of-MSB form. The carry
    // into the MSB is recovered as a_msb ^ b_msb ^ res_msb. With no carry-in
    // this is identical to "operand signs equal and result sign differs",
    // and it stays correct when a carry-in is folded into the sum.
    function automatic adder_flags_t adder_flags_f(
        input logic [ADDER_MAX_WIDTH-1:0] res,
        input logic                       carry_out,
        input logic                       res_msb,
        input logic                       a_msb,
        input logic                       b_msb
    );
        adder_flags_t flags;
        logic         msb_carry_in;
        msb_carry_in   = a_msb ^ b_msb ^ res_msb;
        flags.sign     = res_msb;
        flags.zero     = (res == {ADDER_MAX_WIDTH{1'b0}});
        flags.carry    = carry_out;
        flags.parity   = ^res;
        flags.overflow = msb_carry_in ^ carry_out;
        return flags;
    endfunction

endpackage : beh_adder_pkg

// File: rtl/beh_adder_flags.sv
// Combinational status-flag decoder for the registered adder.
// Maps the (WIDTH+1)-bit sum and the operand MSBs onto adder_flags_t.
// WIDTH must be at least 2 and no larger than ADDER_MAX_WIDTH.
module beh_adder_flags
    import beh_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic [WIDTH:0] sum_i,
    input  logic           a_msb_i,
    input  logic           b_msb_i,
    output adder_flags_t   flags_o
);

    // Result bits without the carry, widened to the helper's fixed width.
    logic [ADDER_MAX_WIDTH-1:0] res_ext_s;

    assign res_ext_s = ADDER_MAX_WIDTH'(sum_i[WIDTH-1:0]);

    // Decode all flags from the same sum so they always agree with the result.
    always_comb begin
        flags_o = adder_flags_f(res_ext_s, sum_i[WIDTH], sum_i[WIDTH-1],
                                a_msb_i, b_msb_i);
    end

endmodule : beh_adder_flags

// File: rtl/beh_16bit_adder.sv
// Registered WIDTH-bit adder with sign/zero/carry/parity/overflow flags.
// Operands qualified by in_valid are added and the sum plus flags appear
// from registers one cycle later; idle cycles hold the last result.
// Optional build macro BEH_ADDER_CIN_EN adds a carry-in port "cin" that is
// sampled together with a and b; without it the adder behaves as cin = 0.
module beh_16bit_adder
    import beh_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef BEH_ADDER_CIN_EN
    input  logic             cin,
`endif
    output logic [WIDTH-1:0] out,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow,
    output logic             out_valid
);

    // Full-width sum including the carry bit.
    logic [WIDTH:0]   sum_s;
    adder_flags_t     flags_s;

    // Next-state and state of the result registers.
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    adder_flags_t     flags_d;
    adder_flags_t     flags_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Zero-extended addition; the bit that falls off the top becomes carry.
`ifdef BEH_ADDER_CIN_EN
    assign sum_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
`else
    assign sum_s = {1'b0, a} + {1'b0, b};
`endif

    beh_adder_flags #(
        .WIDTH   (WIDTH)
    ) u_flags (
        .sum_i   (sum_s),
        .a_msb_i (a[WIDTH-1]),
        .b_msb_i (b[WIDTH-1]),
        .flags_o (flags_s)
    );

    // Load a new result on valid input, otherwise keep the last one.
    always_comb begin
        out_d       = out_q;
        flags_d     = flags_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d   = sum_s[WIDTH-1:0];
            flags_d = flags_s;
        end else begin
            out_d   = out_q;
            flags_d = flags_q;
        end
    end

    // Result, flags and valid share one register stage so they never skew;
    // reset clears everything, including zero, since no result exists yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= {WIDTH{1'b0}};
            flags_q     <= '{sign: 1'b0, zero: 1'b0, carry: 1'b0,
                             parity: 1'b0, overflow: 1'b0};
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign sign      = flags_q.sign;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign parity    = flags_q.parity;
    assign overflow  = flags_q.overflow;
    assign out_valid = out_valid_q;

endmodule : beh_16bit_adder

// File: tb/tb_beh_16bit_adder.sv
// Scoreboard bench for beh_16bit_adder: directed vectors with hand-computed
// results are queued at issue time; a negedge monitor pops and compares
// whenever out_valid is high and checks that idle cycles hold the last result.
module tb_beh_16bit_adder;

    typedef struct packed {
        logic [15:0] out;
        logic        sign;
        logic        zero;
        logic        carry;
        logic        parity;
        logic        overflow;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
`ifdef BEH_ADDER_CIN_EN
    logic        cin;
`endif
    logic [15:0] out;
    logic        sign;
    logic        zero;
    logic        carry;
    logic        parity;
    logic        overflow;
    logic        out_valid;

    exp_t exp_q[$];
    exp_t held;
    int   n_checks = 0;
    int   n_fail   = 0;

    beh_16bit_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
`ifdef BEH_ADDER_CIN_EN
        .cin       (cin),
`endif
        .out       (out),
        .sign      (sign),
        .zero      (zero),
        .carry     (carry),
        .parity    (parity),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".out"},      out,              e.out);
        chk({tag, ".sign"},     {15'd0, sign},     {15'd0, e.sign});
        chk({tag, ".zero"},     {15'd0, zero},     {15'd0, e.zero});
        chk({tag, ".carry"},    {15'd0, carry},    {15'd0, e.carry});
        chk({tag, ".parity"},   {15'd0, parity},   {15'd0, e.parity});
        chk({tag, ".overflow"}, {15'd0, overflow}, {15'd0, e.overflow});
    endtask

    // Issue one valid operation and queue its hand-computed result.
    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                         input logic [15:0] eo, input logic s, input logic z,
                         input logic c, input logic p, input logic o);
        exp_t e;
        @(posedge clk);
        #1;
        a        = va;
        b        = vb;
`ifdef BEH_ADDER_CIN_EN
        cin      = vcin;
`endif
        in_valid = 1'b1;
        e = '{out: eo, sign: s, zero: z, carry: c, parity: p, overflow: o};
        exp_q.push_back(e);
    endtask

    // Idle cycle with changing operands that must be ignored.
    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
`ifdef BEH_ADDER_CIN_EN
        cin      = 1'($urandom);
`endif
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        chk("drain_pending", 16'(exp_q.size()), 16'd0);
    endtask

    // Monitor: compare presented results against the scoreboard, check holds.
    always @(negedge clk) begin
        if (rst) begin
            held = '0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 16'd1, 16'd0);
            end else begin
                held = exp_q.pop_front();
                chk_all("result", held);
            end
        end else begin
            chk_all("hold", held);
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
`ifdef BEH_ADDER_CIN_EN
        cin      = 1'b0;
`endif
        held     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", '0);
        chk("reset.out_valid", {15'd0, out_valid}, 16'd0);
        rst = 1'b0;
        idle();
        idle();

        // Directed single operations.
        issue(16'h8FFF, 16'h8000, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        issue(16'hFFFE, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();

        // Back-to-back burst, then idle with changing operands.
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (4) idle();
        drain();

        // Asynchronous reset between edges, then an operation under reset.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_reset", '0);
        chk("async_reset.out_valid", {15'd0, out_valid}, 16'd0);
        in_valid = 1'b1;
        a        = 16'h8FFF;
        b        = 16'h8000;
        @(posedge clk);
        #1;
        chk_all("reset_held", '0);
        chk("reset_held.out_valid", {15'd0, out_valid}, 16'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        repeat (2) idle();

`ifdef BEH_ADDER_CIN_EN
        issue(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
        issue(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_beh_16bit_adder

// File: doc/beh_16bit_adder.md
Name: beh_16bit_adder

Overview:
- Registered 16-bit two's-complement/unsigned adder with an ALU-style status-flag set: sign, zero, carry, parity and overflow.
- Used as the add datapath of the small ALU/status-register path.
- Operands are sampled on a qualifying clock edge. Sum and flags are presented from registers one cycle later.

Parameters:
- WIDTH, 16, operand/result width. Flag definitions below hold for any WIDTH ≥ 2; 16 is the verified configuration.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies a and b this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out  output  WIDTH  registered sum, a+b mod 2^WIDTH
- sign  output  1  out[WIDTH-1]
- zero  output  1  1 when out == 0
- carry  output  1  unsigned carry-out, bit WIDTH of a+b
- parity  output  1  XOR-reduction of out (1 = odd number of ones)
- overflow  output  1  signed overflow
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Reset: rst high asynchronously clears out, sign, zero, carry, parity, overflow and out_valid to 0. Zero is 0 during reset because no result exists yet. Outputs stay 0 until the first accepted operation after rst deasserts.
- Sum: compute the full (WIDTH+1)-bit sum {carry, sum} = a + b, zero-extended.
- Overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
- All flags are derived from the same combinational sum and registered in the same edge as out. Flags never lag or lead out.
- Latency: 1 cycle. On a rising clk edge with in_valid=1, out and flags load the new result and out_valid goes 1.
- With in_valid=0, out and flags hold their previous values and out_valid goes 0.
- Throughput: one operation per cycle, back-to-back; no stall or backpressure.
- Wrap-around: the sum is modulo 2^WIDTH; the lost bit appears only on carry.
- Carry and overflow are independent. Both, either or neither may be set.
- Reset mid-operation: an operation sampled in the same cycle that rst asserts is discarded. There is no pending state.
- No X-propagation requirement on a and b when in_valid=0.

Optional Feature:
- Macro BEH_ADDER_CIN_EN.
- Defined: adds input port cin (1 bit, sampled with a and b). Sum = a + b + cin. Carry and overflow include cin; for overflow, use the MSB carry-in XOR carry-out formulation.
- Undefined: no cin port; behaviour is exactly as specified above, equivalent to cin=0.

Decomposition:
- Package beh_adder_pkg holds:
  - the ADDER_WIDTH=16 localparam
  - a packed struct adder_flags_t {sign, zero, carry, parity, overflow}
  - a function computing adder_flags_t from the (WIDTH+1)-bit sum and the operand MSBs
- Natural sub-module: beh_adder_flags, a combinational block mapping sum and operand MSBs to adder_flags_t.
- The top instantiates beh_adder_flags and holds the adder and output registers.

Test Plan:
- Reset: assert rst mid-simulation without a clock edge → all outputs 0 immediately; hold rst, pulse clk with in_valid=1 → outputs remain 0.
- a=16'h8FFF, b=16'h8000, in_valid=1 → next cycle out=16'h0FFF, sign=0, zero=0, carry=1, parity=0, overflow=1, out_valid=1.
- a=16'hFFFE, b=16'h0002 → out=16'h0000, sign=0, zero=1, carry=1, parity=0, overflow=0.
- a=16'hAAAA, b=16'h5555 → out=16'hFFFF, sign=1, zero=0, carry=0, parity=0, overflow=0.
- a=16'h7FFF, b=16'h0001 → out=16'h8000, sign=1, zero=0, carry=0, parity=1, overflow=1.
- Back-to-back then idle: three valid ops on consecutive cycles produce results on consecutive cycles. Then in_valid=0 with changing a and b → out and flags hold the last result and out_valid=0.
- With BEH_ADDER_CIN_EN: a=16'hFFFF, b=0, cin=1 → out=0, zero=1, carry=1, overflow=0.
